// File: rtl/uart_src_arbiter.sv
// Round-robin front end that time-shares one UartSource frame transmitter
// between NREQ requesters, with a watchdog on the transmitter's done pulse.
module uart_src_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 65536,
    parameter int CNTW    = 32
) (
    input  logic                 iCLOCK,
    input  logic                 iNRESET,
    input  logic [NREQ-1:0]      iREQ,
    input  logic [64*NREQ-1:0]   iDATA,
    input  logic                 iSRC_DONE,
    output logic                 oSRC_EN,
    output logic [63:0]          oSRC_DATA,
    output logic [NREQ-1:0]      oGRANT,
    output logic [NREQ-1:0]      oACK,
    output logic [NREQ-1:0]      oERR,
    output logic                 oBUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IW-1:0]     rr_r;
    logic [IW-1:0]     owner_r;
    logic [CNTW-1:0]   cnt_r;
    logic [IW-1:0]     win_s;
    logic [IW-1:0]     cand_s;
    logic              win_vld_s;
    logic              tmo_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign tmo_s = (cnt_r == CNTW'(TIMEOUT - 1));

    // Round-robin pick: walk downward so the nearest request at or above rr wins.
    always_comb begin
        win_s     = rr_r;
        cand_s    = rr_r;
        win_vld_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_s = IW'((int'(rr_r) + i) % NREQ);
            if (iREQ[cand_s]) begin
                win_s     = cand_s;
                win_vld_s = 1'b1;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) state_s = ST_LOAD;
                else           state_s = ST_IDLE;
            end
            ST_LOAD:  state_s = ST_START;
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (iSRC_DONE || tmo_s) state_s = ST_ACK;
                else                    state_s = ST_WAIT;
            end
            ST_ACK:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge iCLOCK or negedge iNRESET) begin
        if (!iNRESET) begin
            rr_r      <= '0;
            owner_r   <= '0;
            cnt_r     <= '0;
            oSRC_EN   <= 1'b0;
            oSRC_DATA <= 64'h0;
            oGRANT    <= '0;
            oACK      <= '0;
            oERR      <= '0;
            oBUSY     <= 1'b0;
        end else begin
            oSRC_EN <= (state_s == ST_START);
            oBUSY   <= (state_s != ST_IDLE);
            if (state_r == ST_IDLE && state_s == ST_LOAD) begin
                owner_r   <= win_s;
                oGRANT    <= onehot(win_s);
                oSRC_DATA <= iDATA[64*int'(win_s) +: 64];
            end else if (state_r == ST_ACK) begin
                oGRANT <= '0;
                rr_r   <= (owner_r == IW'(NREQ - 1)) ? '0 : owner_r + {{(IW-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_START) begin
                cnt_r <= '0;
            end else if (state_r == ST_WAIT && cnt_r != {CNTW{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
            // A done pulse coinciding with the timeout counts as a clean completion.
            if (state_r == ST_WAIT && state_s == ST_ACK) begin
                oACK <= onehot(owner_r);
                oERR <= iSRC_DONE ? '0 : onehot(owner_r);
            end else begin
                oACK <= '0;
                oERR <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_src_arbiter.sv
// Directed self-checking bench for uart_src_arbiter with NREQ=2 and a
// short watchdog so timeout paths are reachable.
module tb_uart_src_arbiter;

    logic         iCLOCK = 1'b0;
    logic         iNRESET = 1'b0;
    logic [1:0]   iREQ = 2'b00;
    logic [127:0] iDATA = 128'h0;
    logic         iSRC_DONE = 1'b0;
    logic         oSRC_EN;
    logic [63:0]  oSRC_DATA;
    logic [1:0]   oGRANT;
    logic [1:0]   oACK;
    logic [1:0]   oERR;
    logic         oBUSY;

    int checks_r = 0;
    int errors_r = 0;

    localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D1 = 64'hFEDCBA9876543210;

    uart_src_arbiter #(.NREQ(2), .TIMEOUT(16), .CNTW(32)) dut (
        .iCLOCK(iCLOCK), .iNRESET(iNRESET), .iREQ(iREQ), .iDATA(iDATA),
        .iSRC_DONE(iSRC_DONE), .oSRC_EN(oSRC_EN), .oSRC_DATA(oSRC_DATA),
        .oGRANT(oGRANT), .oACK(oACK), .oERR(oERR), .oBUSY(oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"},   {63'h0, oSRC_EN}, 64'h0);
        check({tag, "_grant"}, {62'h0, oGRANT}, 64'h0);
        check({tag, "_ack"},  {62'h0, oACK}, 64'h0);
        check({tag, "_err"},  {62'h0, oERR}, 64'h0);
        check({tag, "_busy"}, {63'h0, oBUSY}, 64'h0);
    endtask

    task automatic do_reset();
        iNRESET = 1'b0;
        step();
        step();
        iNRESET = 1'b1;
    endtask

    // One frame: expects oSRC_EN 2 cycles after entry, done after d WAIT-side
    // cycles (d<0: never), ack/err timing, then one idle cycle with re-raise.
    task automatic run_frame(input string tag, input logic [1:0] g, input int d,
                             input logic [63:0] data, input logic [1:0] rer,
                             input logic early);
        int n;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n = k;
            if (oSRC_EN) break;
        end
        check({tag, "_en_lat"}, 64'(n), 64'd2);
        check({tag, "_grant"}, {62'h0, oGRANT}, {62'h0, g});
        check({tag, "_data"}, oSRC_DATA, data);
        check({tag, "_busy"}, {63'h0, oBUSY}, 64'h1);
        if (early) iREQ = iREQ & ~g;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            iSRC_DONE = (d >= 1 && k == d + 1);
            step();
            n = k;
            if (oACK != 2'b00) break;
        end
        iSRC_DONE = 1'b0;
        check({tag, "_ack_lat"}, 64'(n), (d >= 1) ? 64'(d + 1) : 64'd17);
        check({tag, "_ack"}, {62'h0, oACK}, {62'h0, g});
        check({tag, "_err"}, {62'h0, oERR}, (d >= 1) ? 64'h0 : {62'h0, g});
        iREQ = iREQ & ~g;
        step();
        check({tag, "_idle_grant"}, {62'h0, oGRANT}, 64'h0);
        check({tag, "_idle_busy"}, {63'h0, oBUSY}, 64'h0);
        check({tag, "_data_hold"}, oSRC_DATA, data);
        iREQ = iREQ | rer;
    endtask

    initial begin
        int en_cnt;
        iDATA = {D1, D0};
        do_reset();
        check_idle_outputs("reset");
        check("reset_data", oSRC_DATA, 64'h0);

        // Stray done in IDLE is ignored.
        iSRC_DONE = 1'b1;
        step();
        iSRC_DONE = 1'b0;
        step();
        check_idle_outputs("stray_done");

        iREQ = 2'b01;
        run_frame("single", 2'b01, 5, D0, 2'b00, 1'b0);

        // Simultaneous requests from reset.
        do_reset();
        iREQ = 2'b11;
        run_frame("sim0", 2'b01, 3, D0, 2'b00, 1'b0);
        run_frame("sim1", 2'b10, 2, D1, 2'b00, 1'b0);
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (oSRC_EN) en_cnt++;
        end
        check("sim_no_extra_en", 64'(en_cnt), 64'd0);

        // Fairness: both re-raise after every ack.
        iREQ = 2'b11;
        for (int f = 0; f < 6; f++) begin
            run_frame("fair", (f % 2 == 0) ? 2'b01 : 2'b10, 1 + f, (f % 2 == 0) ? D0 : D1,
                      (f == 5) ? 2'b00 : ((f % 2 == 0) ? 2'b01 : 2'b10), 1'b0);
        end
        iREQ = 2'b00;
        step();

        // Timeout, pointer advance with early drop, then done/timeout collision.
        do_reset();
        iREQ = 2'b01;
        run_frame("timeout", 2'b01, -1, D0, 2'b11, 1'b0);
        run_frame("rr_adv", 2'b10, 2, D1, 2'b00, 1'b1);
        run_frame("collide", 2'b01, 16, D0, 2'b00, 1'b0);
        iREQ = 2'b00;
        step();

        // Reset in the middle of WAIT.
        iREQ = 2'b01;
        step();
        step();
        check("rst_mid_en", {63'h0, oSRC_EN}, 64'h1);
        step();
        step();
        step();
        iNRESET = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        check("rst_async_data", oSRC_DATA, 64'h0);
        iREQ = 2'b10;
        step();
        check("rst_hold_ack", {62'h0, oACK}, 64'h0);
        iNRESET = 1'b1;
        run_frame("after_rst", 2'b10, 2, D1, 2'b00, 1'b0);
        iREQ = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule

// File: doc/uart_src_arbiter.md
# uart_src_arbiter

Round-robin arbiter and sequencer that shares one `UartSource` 64-bit frame transmitter between `NREQ` requesters, such as the kernel response path and a status/debug path. It latches the winning requester's 64-bit word and pulses the source's start input. It then waits for the source's done pulse, or a watchdog timeout, and returns a per-requester acknowledge. It sits between the host-side protocol logic and the `UartSource` instance driving the TX pin.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `TIMEOUT`, 65536: maximum cycles to wait for `iSRC_DONE` after the start pulse. One 8-byte frame at 115200 baud / 50 MHz is about 34720 cycles.
- `CNTW`, 32: watchdog counter width.

Ports:
- `iCLOCK`  in  1  single system clock; all state updates on the rising edge.
- `iNRESET`  in  1  asynchronous, active-low reset.
- `iREQ`  in  NREQ  request level per requester. Held high until `oACK[k]` is seen, then dropped at that edge.
- `iDATA`  in  64*NREQ  requester k word at `[64k+63:64k]`. Stable while `iREQ[k]` is high and not yet granted.
- `iSRC_DONE`  in  1  one-cycle done pulse from `UartSource.oDONE`.
- `oSRC_EN`  out  1  one-cycle start pulse to `UartSource.iFEN`.
- `oSRC_DATA`  out  64  frame word to `UartSource.iFDATA`.
- `oGRANT`  out  NREQ  one-hot current owner; zero when idle.
- `oACK`  out  NREQ  one-cycle completion pulse to the served requester.
- `oERR`  out  NREQ  one-cycle pulse coincident with `oACK` when the frame timed out.
- `oBUSY`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered.
- States and transitions:
  - IDLE: if `iREQ != 0`, go to LOAD; otherwise stay.
  - LOAD: go to START.
  - START: go to WAIT.
  - WAIT: if `iSRC_DONE` or the counter has reached `TIMEOUT-1`, go to ACK; otherwise stay.
  - ACK: go to IDLE.
- Arbitration happens at the IDLE->LOAD edge. The winner is the first k with `iREQ[k]` set, searching upward from pointer `rr` and wrapping modulo NREQ.
- At IDLE->LOAD: `oGRANT` is set one-hot to the winner, `oSRC_DATA` takes the winner's `iDATA` slice, and the owner index is stored.
- START: `oSRC_EN` is high for exactly this one cycle.
- WAIT: counter increments from 0 each cycle and saturates; cleared on entry to WAIT.
- ACK: `oACK[owner]` is high for one cycle. `oERR[owner]` is also high if exit from WAIT was by timeout.
  - On leaving ACK, `rr` becomes (owner+1) mod NREQ.
  - `oGRANT` clears to 0 on entry to IDLE.
- `oSRC_DATA` is held constant from LOAD through ACK and keeps its last value in IDLE.
- Boundary rules:
  - `iSRC_DONE` and the timeout in the same WAIT cycle: the done wins and `oERR` stays 0.
  - `iSRC_DONE` outside WAIT is ignored and not remembered.
  - A requester dropping `iREQ` after LOAD does not abort: the frame completes and `oACK` is still issued.
  - A requester re-raising `iREQ` in the IDLE cycle after its ACK competes normally, behind the rotated pointer.
  - A reset assertion in any state forces IDLE asynchronously. No `oACK` is issued for the aborted frame. `UartSource` shares `iNRESET`.
- Reset values: state IDLE, `rr`=0, counter 0, and all outputs 0 (`oSRC_EN`, `oSRC_DATA`, `oGRANT`, `oACK`, `oERR`, `oBUSY`).

## Timing
- Latency:
  - `iREQ` sampled high at edge E0 (state IDLE) -> LOAD during cycle E0..E1.
  - `oSRC_EN` high during cycle E1..E2; WAIT from E2.
  - `iSRC_DONE` sampled at edge Ed -> `oACK` high during cycle Ed..Ed+1 -> IDLE at Ed+1.
- Request-to-start is 2 cycles. Done-to-ack is 1 cycle.
- Back-to-back: the next frame's `oSRC_EN` comes 3 cycles after the previous `oACK` cycle (IDLE, LOAD, START).
- Timeout: `oACK`+`oERR` assert exactly `TIMEOUT`+1 cycles after the `oSRC_EN` cycle ends, when no done pulse arrives.
- `oBUSY` rises with LOAD and falls on entry to IDLE.

## Test plan
- Single request, NREQ=2: `iREQ`=01, `iDATA[63:0]`=0x0123456789ABCDEF, with a real `UartSource` (50 MHz / 115200).
  - Expect `oSRC_EN` 2 cycles after the request and TX byte order EF, CD, AB, 89, 67, 45, 23, 01.
  - Expect `oACK`=01 1 cycle after `oDONE`, with `oERR`=00.
- Simultaneous requests: `iREQ`=11 from reset -> requester 0 served first, then requester 1. Exactly two `oSRC_EN` pulses; `oGRANT` sequence 01, 10.
- Fairness: both requesters held high for 6 frames (each re-raising after its ack) -> grants strictly alternate 0,1,0,1,0,1.
- Timeout: stubbed `iSRC_DONE`=0, TIMEOUT=16 -> `oACK[0]`=`oERR[0]`=1 exactly 17 cycles after the `oSRC_EN` cycle; `rr` advances to 1.
- Collision: `iSRC_DONE` pulsed in the same cycle the counter reaches TIMEOUT-1 -> `oACK`=1, `oERR`=0.
- Reset mid-WAIT: assert `iNRESET`=0 for 1 cycle during WAIT.
  - Expect all outputs 0 immediately and no `oACK`.
  - After release with `iREQ`=10, expect requester 1 to be granted (pointer back at 0, no higher request).
